// File: rtl/frame_render_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : frame_render_sequencer
//  Purpose  : Per-frame sequencing of a back-buffer clear followed by one
//             rasterizer launch per triangle slot, with overrun accounting
//             for start pulses that arrive while a frame is in flight.
//  Revision : 1.0 - initial release
// ============================================================================
module frame_render_sequencer #(
    parameter int HORIZ_RESOLUTION = 80,
    parameter int VERT_RESOLUTION  = 60,
    parameter int COLOR_DEPTH      = 12,
    parameter int MAX_TRIANGLES    = 8,
    localparam int CNT_W = $clog2(MAX_TRIANGLES + 1),
    localparam int IDX_W = $clog2(MAX_TRIANGLES),
    localparam int VA_W  = $clog2(VERT_RESOLUTION),
    localparam int HA_W  = $clog2(HORIZ_RESOLUTION)
) (
    input  logic                   i_clk,
    input  logic                   i_arst,
    input  logic                   i_new_frame,
    input  logic                   i_clear_en,
    input  logic [COLOR_DEPTH-1:0] i_bg_color,
    input  logic [CNT_W-1:0]       i_num_triangles,
    input  logic                   i_raster_done,
    output logic                   o_raster_go,
    output logic [IDX_W-1:0]       o_tri_index,
    output logic [VA_W-1:0]        o_clear_vert_addr,
    output logic [HA_W-1:0]        o_clear_horiz_addr,
    output logic                   o_clear_write_en,
    output logic [COLOR_DEPTH-1:0] o_clear_pixel_data,
    output logic                   o_raster_in_progress,
    output logic                   o_frame_done,
    output logic [7:0]             o_overrun_count
);

    localparam logic [HA_W-1:0]  C_H_LAST  = HA_W'(HORIZ_RESOLUTION - 1);
    localparam logic [VA_W-1:0]  C_V_LAST  = VA_W'(VERT_RESOLUTION - 1);
    localparam logic [CNT_W-1:0] C_MAX_TRI = CNT_W'(MAX_TRIANGLES);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CLEAR     = 3'd1,
        ST_LAUNCH    = 3'd2,
        ST_WAIT_ACK  = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_FINISH    = 3'd5
    } state_t;

    state_t                 state_q;
    logic                   raster_go_q;
    logic [IDX_W-1:0]       tri_index_q;
    logic [VA_W-1:0]        vert_q;
    logic [HA_W-1:0]        horiz_q;
    logic                   write_en_q;
    logic [COLOR_DEPTH-1:0] pixel_q;
    logic                   in_progress_q;
    logic                   frame_done_q;
    logic [7:0]             overrun_q;
    logic [CNT_W-1:0]       count_q;
    logic [CNT_W-1:0]       slot_q;

    logic [CNT_W-1:0]       num_clamped_d;
    logic [CNT_W-1:0]       slot_d;

    // Requested triangle count limited to the number of descriptor slots,
    // and the slot that follows the one currently being rasterized.
    assign num_clamped_d = (i_num_triangles > C_MAX_TRI) ? C_MAX_TRI : i_num_triangles;
    assign slot_d        = slot_q + 1'b1;

    // Frame sequencer: state plus every output register, updated together.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state_q       <= ST_IDLE;
            raster_go_q   <= 1'b0;
            tri_index_q   <= '0;
            vert_q        <= '0;
            horiz_q       <= '0;
            write_en_q    <= 1'b0;
            pixel_q       <= '0;
            in_progress_q <= 1'b0;
            frame_done_q  <= 1'b0;
            overrun_q     <= '0;
            count_q       <= '0;
            slot_q        <= '0;
        end else begin
            raster_go_q  <= 1'b0;
            frame_done_q <= 1'b0;

            // Any start pulse outside IDLE (FINISH included) is an overrun.
            if (i_new_frame && (state_q != ST_IDLE) && (overrun_q != 8'hFF)) begin
                overrun_q <= overrun_q + 8'd1;
            end

            case (state_q)
                ST_IDLE: begin
                    // The busy flag lingers one cycle past FINISH, then drops
                    // unless a new frame is accepted right away.
                    in_progress_q <= 1'b0;
                    if (i_new_frame) begin
                        in_progress_q <= 1'b1;
                        pixel_q       <= i_bg_color;
                        count_q       <= num_clamped_d;
                        slot_q        <= '0;
                        if (i_clear_en) begin
                            state_q    <= ST_CLEAR;
                            write_en_q <= 1'b1;
                            vert_q     <= '0;
                            horiz_q    <= '0;
                        end else if (num_clamped_d != '0) begin
                            state_q     <= ST_LAUNCH;
                            raster_go_q <= 1'b1;
                            tri_index_q <= '0;
                        end else begin
                            state_q      <= ST_FINISH;
                            frame_done_q <= 1'b1;
                        end
                    end
                end

                ST_CLEAR: begin
                    // Raster-order sweep, horizontal address fastest.
                    if (horiz_q == C_H_LAST) begin
                        horiz_q <= '0;
                        if (vert_q == C_V_LAST) begin
                            vert_q     <= '0;
                            write_en_q <= 1'b0;
                            if (count_q != '0) begin
                                state_q     <= ST_LAUNCH;
                                raster_go_q <= 1'b1;
                                tri_index_q <= '0;
                            end else begin
                                state_q      <= ST_FINISH;
                                frame_done_q <= 1'b1;
                            end
                        end else begin
                            vert_q <= vert_q + 1'b1;
                        end
                    end else begin
                        horiz_q <= horiz_q + 1'b1;
                    end
                end

                ST_LAUNCH: begin
                    state_q <= ST_WAIT_ACK;
                end

                // One blind cycle lets the rasterizer drop its idle flag.
                ST_WAIT_ACK: begin
                    state_q <= ST_WAIT_DONE;
                end

                ST_WAIT_DONE: begin
                    if (i_raster_done) begin
                        slot_q <= slot_d;
                        if (slot_d < count_q) begin
                            state_q     <= ST_LAUNCH;
                            raster_go_q <= 1'b1;
                            tri_index_q <= slot_d[IDX_W-1:0];
                        end else begin
                            state_q      <= ST_FINISH;
                            frame_done_q <= 1'b1;
                        end
                    end
                end

                ST_FINISH: begin
                    state_q <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_raster_go          = raster_go_q;
    assign o_tri_index          = tri_index_q;
    assign o_clear_vert_addr    = vert_q;
    assign o_clear_horiz_addr   = horiz_q;
    assign o_clear_write_en     = write_en_q;
    assign o_clear_pixel_data   = pixel_q;
    assign o_raster_in_progress = in_progress_q;
    assign o_frame_done         = frame_done_q;
    assign o_overrun_count      = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_frame_render_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_frame_render_sequencer
//  Purpose  : Self-checking bench for frame_render_sequencer with a simple
//             rasterizer model and frame-level expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_frame_render_sequencer;

    localparam int H    = 80;
    localparam int V    = 60;
    localparam int MAXT = 8;

    logic        i_clk = 1'b0;
    logic        i_arst;
    logic        i_new_frame;
    logic        i_clear_en;
    logic [11:0] i_bg_color;
    logic [3:0]  i_num_triangles;
    logic        i_raster_done = 1'b1;
    logic        o_raster_go;
    logic [2:0]  o_tri_index;
    logic [5:0]  o_clear_vert_addr;
    logic [6:0]  o_clear_horiz_addr;
    logic        o_clear_write_en;
    logic [11:0] o_clear_pixel_data;
    logic        o_raster_in_progress;
    logic        o_frame_done;
    logic [7:0]  o_overrun_count;

    frame_render_sequencer #(
        .HORIZ_RESOLUTION(H),
        .VERT_RESOLUTION (V),
        .COLOR_DEPTH     (12),
        .MAX_TRIANGLES   (MAXT)
    ) dut (
        .i_clk               (i_clk),
        .i_arst              (i_arst),
        .i_new_frame         (i_new_frame),
        .i_clear_en          (i_clear_en),
        .i_bg_color          (i_bg_color),
        .i_num_triangles     (i_num_triangles),
        .i_raster_done       (i_raster_done),
        .o_raster_go         (o_raster_go),
        .o_tri_index         (o_tri_index),
        .o_clear_vert_addr   (o_clear_vert_addr),
        .o_clear_horiz_addr  (o_clear_horiz_addr),
        .o_clear_write_en    (o_clear_write_en),
        .o_clear_pixel_data  (o_clear_pixel_data),
        .o_raster_in_progress(o_raster_in_progress),
        .o_frame_done        (o_frame_done),
        .o_overrun_count     (o_overrun_count)
    );

    always #5 i_clk = ~i_clk;

    int checks   = 0;
    int failures = 0;

    // Rasterizer model: after seeing a go pulse it reports busy so that the
    // sequencer observes done low for ras_delay of its wait cycles.
    int ras_delay = 1;
    int ras_rem   = 0;
    always @(negedge i_clk) begin
        if (i_arst) begin
            ras_rem       = 0;
            i_raster_done = 1'b1;
        end else if (o_raster_go) begin
            ras_rem       = ras_delay + 1;
            i_raster_done = 1'b0;
        end else if (ras_rem > 0) begin
            ras_rem       = ras_rem - 1;
            i_raster_done = (ras_rem == 0);
        end
    end

    // Statistics collected over one frame.
    int st_strobes, st_addr_err, st_first, st_last;
    int st_done_cnt, st_done_cyc, st_inprog, st_idx_err;
    int go_cyc[$];
    int go_idx[$];

    function automatic int clamp_tris(input int num);
        return (num > MAXT) ? MAXT : num;
    endfunction

    task automatic do_reset();
        i_arst = 1'b1;
        repeat (2) @(negedge i_clk);
        i_arst = 1'b0;
        @(negedge i_clk);
    endtask

    // Start one frame and observe it; cycle 0 is the cycle after acceptance.
    task automatic run_frame(input logic clr, input logic [11:0] bg, input int num,
                             input int d, input bit storm, input bit pulse_on_done);
        logic [2:0] cur_idx;
        int         tail;
        ras_delay = d;
        @(negedge i_clk);
        i_clear_en      = clr;
        i_bg_color      = bg;
        i_num_triangles = 4'(num);
        i_new_frame     = 1'b1;
        @(negedge i_clk);
        i_new_frame     = 1'b0;
        i_clear_en      = 1'($urandom);
        i_bg_color      = 12'($urandom);
        i_num_triangles = 4'($urandom);
        st_strobes = 0; st_addr_err = 0; st_first = -1; st_last = -1;
        st_done_cnt = 0; st_done_cyc = -1; st_inprog = 0; st_idx_err = 0;
        go_cyc.delete(); go_idx.delete();
        cur_idx = '0;
        tail    = 0;
        for (int c = 0; c < 12000; c++) begin
            i_new_frame = 1'b0;
            if (o_clear_write_en) begin
                if ((int'(o_clear_vert_addr) != st_strobes / H) ||
                    (int'(o_clear_horiz_addr) != st_strobes % H) ||
                    (o_clear_pixel_data !== bg))
                    st_addr_err++;
                if (st_strobes == 0) st_first = c;
                st_last = c;
                st_strobes++;
            end
            if (o_raster_go) begin
                go_cyc.push_back(c);
                go_idx.push_back(int'(o_tri_index));
                cur_idx = o_tri_index;
            end else if (st_done_cnt == 0 && go_idx.size() > 0 && o_tri_index !== cur_idx) begin
                st_idx_err++;
            end
            if (o_frame_done) begin
                st_done_cnt++;
                st_done_cyc = c;
                if (pulse_on_done) i_new_frame = 1'b1;
            end
            if (o_raster_in_progress) st_inprog++;
            if (storm && c >= 1 && c <= 599 && (c % 2) == 1) i_new_frame = 1'b1;
            if (!o_raster_in_progress && st_done_cnt > 0) begin
                tail++;
                if (tail >= 20) break;
            end
            @(negedge i_clk);
        end
        i_new_frame = 1'b0;
    endtask

    task automatic test_reset();
        i_arst = 1'b1; i_new_frame = 1'b0; i_clear_en = 1'b0;
        i_bg_color = '0; i_num_triangles = '0;
        repeat (3) @(negedge i_clk);
        checks++;
        if ({o_raster_go, o_clear_write_en, o_raster_in_progress, o_frame_done} !== 4'b0) begin
            failures++;
            $display("FAIL reset_strobes got=%b exp=0000",
                     {o_raster_go, o_clear_write_en, o_raster_in_progress, o_frame_done});
        end
        checks++;
        if ({o_tri_index, o_clear_vert_addr, o_clear_horiz_addr, o_clear_pixel_data, o_overrun_count} !== '0) begin
            failures++;
            $display("FAIL reset_values got idx=%0d v=%0d h=%0d pix=%h ovr=%0d exp all 0",
                     o_tri_index, o_clear_vert_addr, o_clear_horiz_addr, o_clear_pixel_data, o_overrun_count);
        end
        i_arst = 1'b0;
        @(negedge i_clk);
    endtask

    task automatic test_clear_frame();
        logic [11:0] bg;
        bg = 12'hF00;
        run_frame(1'b1, bg, 0, 1, 1'b0, 1'b0);
        checks++;
        if (st_strobes != H * V) begin
            failures++; $display("FAIL clear_count got=%0d exp=%0d", st_strobes, H * V);
        end
        checks++;
        if (st_addr_err != 0) begin
            failures++; $display("FAIL clear_addr_data bad_strobes=%0d exp=0", st_addr_err);
        end
        checks++;
        if (st_first != 0 || st_last != H * V - 1) begin
            failures++; $display("FAIL clear_span got=%0d..%0d exp=0..%0d", st_first, st_last, H * V - 1);
        end
        checks++;
        if (st_done_cnt != 1 || st_done_cyc != H * V) begin
            failures++; $display("FAIL clear_done got cnt=%0d cyc=%0d exp cnt=1 cyc=%0d",
                                 st_done_cnt, st_done_cyc, H * V);
        end
        checks++;
        if (st_inprog != H * V + 2) begin
            failures++; $display("FAIL clear_inprog got=%0d exp=%0d", st_inprog, H * V + 2);
        end
        checks++;
        if (go_cyc.size() != 0) begin
            failures++; $display("FAIL clear_no_go got=%0d exp=0", go_cyc.size());
        end
    endtask

    task automatic test_triangles();
        int nums[7];
        int dls[7];
        nums[0] = 3; dls[0] = 10;
        nums[1] = 0; dls[1] = 2;
        for (int i = 2; i < 7; i++) begin
            nums[i] = int'($urandom_range(0, 12));
            dls[i]  = int'($urandom_range(1, 8));
        end
        for (int i = 0; i < 7; i++) begin
            int n, d, gerr, exp_done;
            n = clamp_tris(nums[i]);
            d = dls[i];
            run_frame(1'b0, 12'($urandom), nums[i], d, 1'b0, 1'b0);
            gerr = 0;
            for (int k = 0; k < go_cyc.size(); k++)
                if (go_idx[k] != k || go_cyc[k] != k * (d + 2)) gerr++;
            exp_done = n * (d + 2);
            checks++;
            if (go_cyc.size() != n) begin
                failures++; $display("FAIL tri_go_count num=%0d got=%0d exp=%0d", nums[i], go_cyc.size(), n);
            end
            checks++;
            if (gerr != 0) begin
                failures++; $display("FAIL tri_go_timing num=%0d d=%0d bad=%0d exp=0", nums[i], d, gerr);
            end
            checks++;
            if (st_done_cnt != 1 || st_done_cyc != exp_done || st_inprog != exp_done + 2) begin
                failures++; $display("FAIL tri_done num=%0d got cnt=%0d cyc=%0d inprog=%0d exp cnt=1 cyc=%0d inprog=%0d",
                                     nums[i], st_done_cnt, st_done_cyc, st_inprog, exp_done, exp_done + 2);
            end
            checks++;
            if (st_idx_err != 0 || st_strobes != 0) begin
                failures++; $display("FAIL tri_stable num=%0d idx_err=%0d strobes=%0d exp 0 0",
                                     nums[i], st_idx_err, st_strobes);
            end
        end
    endtask

    task automatic test_clamp();
        run_frame(1'b0, 12'h0AB, 12, 3, 1'b0, 1'b0);
        checks++;
        if (go_cyc.size() != MAXT) begin
            failures++; $display("FAIL clamp_count got=%0d exp=%0d", go_cyc.size(), MAXT);
        end
        checks++;
        if (go_idx.size() == 0 || go_idx[0] != 0 || go_idx[go_idx.size() - 1] != MAXT - 1) begin
            failures++; $display("FAIL clamp_indices got_last=%0d exp=%0d",
                                 (go_idx.size() > 0) ? go_idx[go_idx.size() - 1] : -1, MAXT - 1);
        end
    endtask

    task automatic test_clear_then_draw();
        run_frame(1'b1, 12'h5A5, 2, 5, 1'b0, 1'b0);
        checks++;
        if (st_strobes != H * V || st_addr_err != 0) begin
            failures++; $display("FAIL ctd_clear got=%0d bad=%0d exp=%0d 0", st_strobes, st_addr_err, H * V);
        end
        checks++;
        if (go_cyc.size() != 2 || go_cyc[0] != H * V || go_cyc[1] != H * V + 7) begin
            failures++; $display("FAIL ctd_go got n=%0d first=%0d exp n=2 first=%0d", go_cyc.size(),
                                 (go_cyc.size() > 0) ? go_cyc[0] : -1, H * V);
        end
        checks++;
        if (st_done_cyc != H * V + 14) begin
            failures++; $display("FAIL ctd_done got=%0d exp=%0d", st_done_cyc, H * V + 14);
        end
    endtask

    task automatic test_finish_overrun();
        do_reset();
        run_frame(1'b0, 12'h123, 0, 1, 1'b0, 1'b1);
        checks++;
        if (o_overrun_count !== 8'd1) begin
            failures++; $display("FAIL finish_overrun got=%0d exp=1", o_overrun_count);
        end
        checks++;
        if (st_done_cnt != 1 || st_inprog != 2) begin
            failures++; $display("FAIL finish_no_restart got done=%0d inprog=%0d exp 1 2", st_done_cnt, st_inprog);
        end
    endtask

    task automatic test_overrun_storm();
        do_reset();
        run_frame(1'b1, 12'h0F0, 0, 1, 1'b1, 1'b0);
        checks++;
        if (o_overrun_count !== 8'd255) begin
            failures++; $display("FAIL storm_overrun got=%0d exp=255", o_overrun_count);
        end
        checks++;
        if (st_strobes != H * V || st_addr_err != 0 || st_done_cyc != H * V || st_inprog != H * V + 2) begin
            failures++; $display("FAIL storm_frame got strobes=%0d bad=%0d done=%0d exp %0d 0 %0d",
                                 st_strobes, st_addr_err, st_done_cyc, H * V, H * V);
        end
    endtask

    task automatic test_reset_midclear();
        int found;
        found = -1;
        @(negedge i_clk);
        i_clear_en = 1'b1; i_bg_color = 12'hABC; i_num_triangles = 4'd2; i_new_frame = 1'b1;
        @(negedge i_clk);
        i_new_frame = 1'b0;
        for (int c = 0; c < 6000; c++) begin
            if (o_clear_write_en && o_clear_vert_addr == 6'd30 && o_clear_horiz_addr == 7'd40) begin
                found = c;
                break;
            end
            @(negedge i_clk);
        end
        checks++;
        if (found != 30 * H + 40) begin
            failures++; $display("FAIL midclear_reach got=%0d exp=%0d", found, 30 * H + 40);
        end
        i_arst = 1'b1;
        #1;
        checks++;
        if ({o_raster_go, o_tri_index, o_clear_vert_addr, o_clear_horiz_addr, o_clear_write_en,
             o_clear_pixel_data, o_raster_in_progress, o_frame_done, o_overrun_count} !== '0) begin
            failures++; $display("FAIL midclear_async got v=%0d h=%0d we=%b pix=%h inprog=%b exp all 0",
                                 o_clear_vert_addr, o_clear_horiz_addr, o_clear_write_en,
                                 o_clear_pixel_data, o_raster_in_progress);
        end
        @(negedge i_clk);
        i_arst = 1'b0;
        run_frame(1'b1, 12'h3C3, 0, 1, 1'b0, 1'b0);
        checks++;
        if (st_first != 0 || st_strobes != H * V || st_addr_err != 0) begin
            failures++; $display("FAIL midclear_restart got first=%0d strobes=%0d bad=%0d exp 0 %0d 0",
                                 st_first, st_strobes, st_addr_err, H * V);
        end
    endtask

    initial begin
        test_reset();
        test_clear_frame();
        test_triangles();
        test_clamp();
        test_clear_then_draw();
        test_finish_overrun();
        test_overrun_storm();
        test_reset_midclear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/frame_render_sequencer.md
FRAME_RENDER_SEQUENCER -- requirements
Module: frame_render_sequencer

Interface
REQ-001 Parameter HORIZ_RESOLUTION, default 80: frame buffer width in pixels.
REQ-002 Parameter VERT_RESOLUTION, default 60: frame buffer height in pixels.
REQ-003 Parameter COLOR_DEPTH, default 12: pixel data width.
REQ-004 Parameter MAX_TRIANGLES, default 8: triangle slots per frame.
REQ-005 One clock; reset is asynchronous and active-high.
REQ-006 i_clk  in  1  system clock; all logic rising-edge.
REQ-007 i_arst  in  1  asynchronous active-high reset.
REQ-008 i_new_frame  in  1  one-cycle start pulse from the swapping controller.
REQ-009 i_clear_en  in  1  clear back buffer before drawing; sampled on accepted start.
REQ-010 i_bg_color  in  COLOR_DEPTH  clear color; sampled on accepted start.
REQ-011 i_num_triangles  in  $clog2(MAX_TRIANGLES+1)  triangles to draw; sampled on accepted start.
REQ-012 i_raster_done  in  1  rasterizer idle level (high = idle).
REQ-013 o_raster_go  out  1  one-cycle rasterizer start pulse.
REQ-014 o_tri_index  out  $clog2(MAX_TRIANGLES)  descriptor slot the rasterizer reads.
REQ-015 o_clear_vert_addr  out  $clog2(VERT_RESOLUTION)  clear write row.
REQ-016 o_clear_horiz_addr  out  $clog2(HORIZ_RESOLUTION)  clear write column.
REQ-017 o_clear_write_en  out  1  clear write strobe; also selects clear over rasterizer on the write port.
REQ-018 o_clear_pixel_data  out  COLOR_DEPTH  clear write data.
REQ-019 o_raster_in_progress  out  1  high from accepted start until frame finish.
REQ-020 o_frame_done  out  1  one-cycle pulse at frame finish.
REQ-021 o_overrun_count  out  8  saturating count of ignored starts.

Function
REQ-022 All outputs SHALL be registered.
REQ-023 States SHALL be IDLE, CLEAR, LAUNCH, WAIT_ACK, WAIT_DONE, FINISH.
REQ-024 IDLE + i_new_frame SHALL latch clear_en, bg_color and min(i_num_triangles, MAX_TRIANGLES), and set o_raster_in_progress the next cycle.
REQ-025 From IDLE the next state SHALL be CLEAR if clear_en=1; else LAUNCH if count>0; else FINISH.
REQ-026 CLEAR SHALL write one pixel per cycle, o_clear_write_en=1, o_clear_pixel_data=latched bg_color, horizontal address fastest, from (0,0) to (V-1,H-1): exactly H*V strobes (4800 by default), with no gaps.
REQ-027 First clear strobe SHALL appear the cycle after start acceptance; after the strobe at (V-1,H-1) the next state SHALL be LAUNCH if count>0, else FINISH.
REQ-028 o_clear_write_en SHALL be 0 in every state except CLEAR; clear addresses SHALL return to 0 when leaving CLEAR.
REQ-029 LAUNCH SHALL pulse o_raster_go for exactly one cycle with o_tri_index = current slot (0 on first entry), then go to WAIT_ACK.
REQ-030 WAIT_ACK SHALL last exactly one cycle, ignoring i_raster_done (guard for done deassertion), then go to WAIT_DONE.
REQ-031 WAIT_DONE SHALL hold until i_raster_done=1, then increment the slot and go to LAUNCH if slot < count, else FINISH.
REQ-032 o_tri_index SHALL stay stable from LAUNCH through WAIT_DONE.
REQ-033 FINISH SHALL last one cycle: o_frame_done=1, o_raster_in_progress cleared the next cycle, then IDLE.
REQ-034 i_new_frame outside IDLE SHALL be ignored and SHALL increment o_overrun_count, saturating at 255.
REQ-035 i_new_frame in the FINISH cycle SHALL count as an overrun, not a start.
REQ-036 Parameter/input changes during a frame SHALL have no effect until the next accepted start.

Reset
REQ-037 i_arst SHALL immediately force IDLE and clear all outputs and counters to 0, including mid-clear or mid-triangle.
REQ-038 After i_arst deassertion, the first i_new_frame SHALL start a frame normally; no partial frame SHALL resume.

Verification
REQ-039 clear_en=1, bg=0xF00, num=0, pulse new_frame -> 4800 strobes on consecutive cycles, (0,0)..(59,79), data 0xF00, then a frame_done pulse, in_progress high for exactly 4802 cycles.
REQ-040 clear_en=0, num=3, model rasterizer dropping done for 10 cycles after each go -> go pulses with index 0,1,2, each 12 cycles apart, then frame_done.
REQ-041 num=12 (MAX=8) -> exactly 8 go pulses, indices 0..7.
REQ-042 new_frame pulsed 300 times during a long clear -> o_overrun_count=255, frame completes unaffected.
REQ-043 i_arst asserted at clear address (30,40) -> all outputs 0 at once; next new_frame restarts clear at (0,0).
REQ-044 new_frame coincident with the FINISH cycle -> overrun +1, sequencer returns to IDLE, no new frame starts.
